// File: rtl/stg_pkg.sv
// Shared definitions for the bullet collision scanner.
//   - scan FSM state encoding
//   - default coordinate width and box half-sizes
//   - bullet record layout {valid, x, y}, with helpers that give the
//     field offsets for a given coordinate width
package stg_pkg;

  localparam int COORD_W      = 10;
  localparam int HIT_R_DEF    = 3;
  localparam int BULLET_R_DEF = 4;
  localparam int GRAZE_R_DEF  = 12;

  localparam int BD_Y_LSB = 0;
  localparam int BD_X_LSB = COORD_W;
  localparam int BD_VALID = 2 * COORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } scan_state_t;

  function automatic int bd_y_lsb(input int cw);
    return 0;
  endfunction

  function automatic int bd_x_lsb(input int cw);
    return cw;
  endfunction

  function automatic int bd_valid_bit(input int cw);
    return 2 * cw;
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Axis-aligned box overlap test for one pair of points and one radius.
// Both absolute differences are formed one bit wider than the coordinates,
// so they never wrap: (0, 1023) is 1023 apart, not 1.
// Ports:
//   i_ax, i_ay  first point
//   i_bx, i_by  second point
//   o_overlap   |ax-bx| <= RADIUS and |ay-by| <= RADIUS
module box_overlap
  import stg_pkg::*;
#(
  parameter int CW     = COORD_W,
  parameter int RADIUS = HIT_R_DEF + BULLET_R_DEF
) (
  input  logic [CW-1:0] i_ax,
  input  logic [CW-1:0] i_ay,
  input  logic [CW-1:0] i_bx,
  input  logic [CW-1:0] i_by,
  output logic          o_overlap
);

  localparam logic [CW:0] LIM = (CW + 1)'(RADIUS);

  logic [CW:0] w_dx;
  logic [CW:0] w_dy;

  always_comb begin
    w_dx = (i_ax >= i_bx) ? ({1'b0, i_ax} - {1'b0, i_bx}) : ({1'b0, i_bx} - {1'b0, i_ax});
    w_dy = (i_ay >= i_by) ? ({1'b0, i_ay} - {1'b0, i_by}) : ({1'b0, i_by} - {1'b0, i_ay});
  end

  assign o_overlap = (w_dx <= LIM) && (w_dy <= LIM);

endmodule

// File: rtl/bullet_collision_scanner.sv
// Per-frame collision detector feeding the game-state FSM.
// On an accepted frame_tick the player position is latched and the bullet
// table is read slot 0..N_BULLETS-1 through a 1-cycle-latency port; each
// returned record is box-tested against the player. A single collision pulse
// (and the lowest hit slot in hit_index) is reported at the end of the scan.
// Optional build macro GRAZE_EN adds a graze box test and the graze pulse;
// without it graze is tied low.
// Ports:
//   clk, hard_reset      clock, async active-high reset
//   game_en, game_reset  scan enable / synchronous soft clear
//   frame_tick           frame start pulse
//   player_x, player_y   player centre
//   bullet_rd/addr/data  bullet table read port, data {valid,x,y} one cycle later
//   collision, graze     one-cycle result pulses
//   hit_index            lowest hit slot of the last frame that reported a hit
//   busy, overrun        scan in progress / sticky dropped-tick flag
//
// state     | meaning
// ST_IDLE   | waiting for frame_tick with game_en
// ST_SCAN   | issuing one table read per cycle
// ST_DRAIN  | comparing the last slot's returned data
// ST_REPORT | pulsing results, updating hit_index
module bullet_collision_scanner
  import stg_pkg::*;
#(
  parameter int N_BULLETS = 64,
  parameter int COORD_W   = stg_pkg::COORD_W,
  parameter int HIT_R     = HIT_R_DEF,
  parameter int BULLET_R  = BULLET_R_DEF
`ifdef GRAZE_EN
  ,
  parameter int GRAZE_R   = GRAZE_R_DEF
`endif
) (
  input  logic                         clk,
  input  logic                         hard_reset,
  input  logic                         game_en,
  input  logic                         game_reset,
  input  logic                         frame_tick,
  input  logic [COORD_W-1:0]           player_x,
  input  logic [COORD_W-1:0]           player_y,
  output logic                         bullet_rd,
  output logic [$clog2(N_BULLETS)-1:0] bullet_addr,
  input  logic [2*COORD_W:0]           bullet_data,
  output logic                         collision,
  output logic [$clog2(N_BULLETS)-1:0] hit_index,
  output logic                         busy,
  output logic                         overrun,
  output logic                         graze
);

  localparam int              AW        = $clog2(N_BULLETS);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(N_BULLETS - 1);
  localparam int              VALID_BIT = bd_valid_bit(COORD_W);
  localparam int              X_LSB     = bd_x_lsb(COORD_W);
  localparam int              Y_LSB     = bd_y_lsb(COORD_W);

  scan_state_t         r_state;
  scan_state_t         w_next;
  logic [AW-1:0]       r_addr;
  logic [AW-1:0]       r_cmp_idx;
  logic [AW-1:0]       r_pend_idx;
  logic [AW-1:0]       r_hit_index;
  logic [COORD_W-1:0]  r_px;
  logic [COORD_W-1:0]  r_py;
  logic                r_cmp_valid;
  logic                r_any_hit;
  logic                r_overrun;
  logic                w_start;
  logic                w_report;
  logic                w_cmp_live;
  logic                w_hit_box;
  logic                w_hit;

  // Returned data is only meaningful while a scan is still live; a read in
  // flight when the scan aborts lands in IDLE and is ignored here.
  assign w_cmp_live = r_cmp_valid && bullet_data[VALID_BIT] &&
                      ((r_state == ST_SCAN) || (r_state == ST_DRAIN));
  assign w_hit      = w_cmp_live && w_hit_box;

  box_overlap #(
    .CW     (COORD_W),
    .RADIUS (HIT_R + BULLET_R)
  ) u_hit_box (
    .i_ax      (bullet_data[X_LSB +: COORD_W]),
    .i_ay      (bullet_data[Y_LSB +: COORD_W]),
    .i_bx      (r_px),
    .i_by      (r_py),
    .o_overlap (w_hit_box)
  );

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_report  = 1'b0;
    bullet_rd = 1'b0;
    busy      = 1'b0;
    collision = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_tick && game_en) begin
          w_next  = ST_SCAN;
          w_start = 1'b1;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (!game_en) begin
          w_next = ST_IDLE;
        end else begin
          bullet_rd = 1'b1;
          if (r_addr == LAST_ADDR) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy   = 1'b1;
        w_next = game_en ? ST_REPORT : ST_IDLE;
      end
      ST_REPORT: begin
        busy      = 1'b1;
        w_report  = 1'b1;
        collision = r_any_hit;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Soft clear wins over everything, including a same-cycle frame_tick.
    if (game_reset) begin
      w_next    = ST_IDLE;
      w_start   = 1'b0;
      w_report  = 1'b0;
      bullet_rd = 1'b0;
      collision = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      r_addr      <= '0;
      r_cmp_idx   <= '0;
      r_pend_idx  <= '0;
      r_hit_index <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_cmp_valid <= 1'b0;
      r_any_hit   <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (game_reset) begin
      r_addr      <= '0;
      r_pend_idx  <= '0;
      r_hit_index <= '0;
      r_cmp_valid <= 1'b0;
      r_any_hit   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_cmp_valid <= bullet_rd;
      r_cmp_idx   <= r_addr;
      if (frame_tick && busy) r_overrun <= 1'b1;
      if (w_start) begin
        r_px      <= player_x;
        r_py      <= player_y;
        r_addr    <= '0;
        r_any_hit <= 1'b0;
      end else begin
        if (bullet_rd) r_addr <= r_addr + AW'(1);
        // Slots are visited in ascending order, so the first hit is the lowest.
        if (w_hit && !r_any_hit) begin
          r_any_hit  <= 1'b1;
          r_pend_idx <= r_cmp_idx;
        end
      end
      if (w_report && r_any_hit) r_hit_index <= r_pend_idx;
    end
  end

  assign bullet_addr = r_addr;
  assign hit_index   = r_hit_index;
  assign overrun     = r_overrun;

`ifdef GRAZE_EN
  logic w_graze_box;
  logic r_any_graze;

  box_overlap #(
    .CW     (COORD_W),
    .RADIUS (GRAZE_R + BULLET_R)
  ) u_graze_box (
    .i_ax      (bullet_data[X_LSB +: COORD_W]),
    .i_ay      (bullet_data[Y_LSB +: COORD_W]),
    .i_bx      (r_px),
    .i_by      (r_py),
    .o_overlap (w_graze_box)
  );

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset)      r_any_graze <= 1'b0;
    else if (game_reset) r_any_graze <= 1'b0;
    else if (w_start)    r_any_graze <= 1'b0;
    else if (w_cmp_live && w_graze_box && !w_hit_box) r_any_graze <= 1'b1;
  end

  assign graze = w_report && r_any_graze;
`else
  assign graze = 1'b0;
`endif

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// Directed bench for bullet_collision_scanner with a behavioural bullet table.
module tb_bullet_collision_scanner;

  localparam int N  = 64;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          hard_reset;
  logic          game_en;
  logic          game_reset;
  logic          frame_tick;
  logic [CW-1:0] player_x;
  logic [CW-1:0] player_y;
  logic          bullet_rd;
  logic [5:0]    bullet_addr;
  logic [2*CW:0] bullet_data;
  logic          collision;
  logic [5:0]    hit_index;
  logic          busy;
  logic          overrun;
  logic          graze;

  logic          bv [N];
  logic [CW-1:0] bx [N];
  logic [CW-1:0] by [N];

  int n_cmp = 0;
  int n_bad = 0;

  int n_coll, coll_cyc, n_graze, busy_low, n_rd, addr_err;

  always #5 clk = ~clk;

  bullet_collision_scanner dut (
    .clk         (clk),
    .hard_reset  (hard_reset),
    .game_en     (game_en),
    .game_reset  (game_reset),
    .frame_tick  (frame_tick),
    .player_x    (player_x),
    .player_y    (player_y),
    .bullet_rd   (bullet_rd),
    .bullet_addr (bullet_addr),
    .bullet_data (bullet_data),
    .collision   (collision),
    .hit_index   (hit_index),
    .busy        (busy),
    .overrun     (overrun),
    .graze       (graze)
  );

  always @(posedge clk) begin
    if (bullet_rd) bullet_data <= {bv[bullet_addr], bx[bullet_addr], by[bullet_addr]};
    else           bullet_data <= '0;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      bv[i] = 1'b0;
      bx[i] = '0;
      by[i] = '0;
    end
  endtask

  task automatic set_bullet(input int s, input int x, input int y);
    bv[s] = 1'b1;
    bx[s] = CW'(x);
    by[s] = CW'(y);
  endtask

  // Pulses frame_tick so the DUT samples it at edge t; cycle c is the
  // interval after edge t+c-1. Optional second tick / game_en drop at c.
  task automatic run_frame(input int tick2_at, input int drop_at);
    n_coll = 0; coll_cyc = -1; n_graze = 0; busy_low = -1; n_rd = 0; addr_err = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 80; c++) begin
      if (collision) begin n_coll++; coll_cyc = c; end
      if (graze) n_graze++;
      if (bullet_rd) begin
        n_rd++;
        if (int'(bullet_addr) != c - 1) addr_err++;
      end
      if (!busy && busy_low < 0) busy_low = c;
      frame_tick = (c == tick2_at);
      if (c == drop_at) game_en = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    hard_reset = 1'b1;
    game_en    = 1'b1;
    game_reset = 1'b0;
    frame_tick = 1'b0;
    player_x   = 10'd100;
    player_y   = 10'd100;
    clear_table();
    repeat (3) @(negedge clk);
    check("rst_collision", collision, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_hit_index", hit_index, 0);
    check("rst_bullet_rd", bullet_rd, 0);
    check("rst_graze", graze, 0);
    hard_reset = 1'b0;
    @(negedge clk);

    // T1: single hit at slot 5, latency and address sweep
    set_bullet(5, 105, 98);
    run_frame(-1, -1);
    check("t1_n_coll", n_coll, 1);
    check("t1_coll_cyc", coll_cyc, 66);
    check("t1_busy_low", busy_low, 67);
    check("t1_n_rd", n_rd, 64);
    check("t1_addr_seq_err", addr_err, 0);
    check("t1_hit_index", hit_index, 5);
    check("t1_graze", n_graze, 0);
    check("t1_overrun", overrun, 0);

    // T2: lowest index wins
    clear_table();
    set_bullet(7, 100, 100);
    set_bullet(3, 100, 100);
    run_frame(-1, -1);
    check("t2_n_coll", n_coll, 1);
    check("t2_hit_index", hit_index, 3);

    // T3: no wrap in the difference, and the 7-pixel boundary
    player_x = 10'd0;
    player_y = 10'd0;
    clear_table();
    set_bullet(0, 1023, 0);
    run_frame(-1, -1);
    check("t3_nowrap_n_coll", n_coll, 0);
    check("t3_nowrap_hit_index", hit_index, 3);
    clear_table();
    set_bullet(9, 7, 7);
    run_frame(-1, -1);
    check("t3_edge7_n_coll", n_coll, 1);
    check("t3_edge7_hit_index", hit_index, 9);
    clear_table();
    set_bullet(9, 8, 0);
    run_frame(-1, -1);
    check("t3_edge8_n_coll", n_coll, 0);
    check("t3_edge8_hit_index", hit_index, 9);
    clear_table();
    set_bullet(63, 0, 0);
    run_frame(-1, -1);
    check("t3_last_slot_n_coll", n_coll, 1);
    check("t3_last_slot_hit_index", hit_index, 63);

    // tick with game_en low is ignored
    game_en = 1'b0;
    run_frame(-1, -1);
    check("ign_busy_low", busy_low, 1);
    check("ign_n_rd", n_rd, 0);
    check("ign_overrun", overrun, 0);
    game_en = 1'b1;

    // T4: second tick while busy is dropped and sets overrun
    player_x = 10'd100;
    player_y = 10'd100;
    clear_table();
    set_bullet(2, 100, 100);
    run_frame(10, -1);
    check("t4_n_coll", n_coll, 1);
    check("t4_busy_low", busy_low, 67);
    check("t4_n_rd", n_rd, 64);
    check("t4_overrun", overrun, 1);
    check("t4_hit_index", hit_index, 2);
    game_reset = 1'b1;
    @(negedge clk);
    game_reset = 1'b0;
    check("t4_clr_overrun", overrun, 0);
    check("t4_clr_hit_index", hit_index, 0);

    // T5: game_en drops at t+20 with a hit pending at slot 2
    run_frame(-1, 20);
    check("t5_abort_n_coll", n_coll, 0);
    check("t5_abort_busy_low", busy_low, 21);
    check("t5_abort_hit_index", hit_index, 0);
    game_en = 1'b1;
    run_frame(-1, -1);
    check("t5_next_n_coll", n_coll, 1);
    check("t5_next_coll_cyc", coll_cyc, 66);
    check("t5_next_hit_index", hit_index, 2);

`ifdef GRAZE_EN
    // T6: graze versus hit
    clear_table();
    set_bullet(4, 110, 100);
    run_frame(-1, -1);
    check("t6_graze_n_graze", n_graze, 1);
    check("t6_graze_n_coll", n_coll, 0);
    clear_table();
    set_bullet(4, 104, 100);
    run_frame(-1, -1);
    check("t6_hit_n_coll", n_coll, 1);
    check("t6_hit_n_graze", n_graze, 0);
`else
    clear_table();
    set_bullet(4, 110, 100);
    run_frame(-1, -1);
    check("t6_nograze_n_graze", n_graze, 0);
    check("t6_nograze_n_coll", n_coll, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bullet_collision_scanner.md
Name: bullet_collision_scanner

Overview:
Per-frame collision detector that sits directly upstream of the game-state FSM and drives its collision input. On each frame tick it latches the player position and walks the bullet table through a 1-cycle-latency read port, doing an axis-aligned box overlap test on each active bullet. At the end of the scan it emits a single-cycle collision pulse if any bullet overlapped the player hitbox.

Parameters:
N_BULLETS, 64, number of bullet table slots; power of two, at least 2
COORD_W, 10, width of x and y coordinates (unsigned pixels)
HIT_R, 3, player hitbox half-size in pixels
BULLET_R, 4, bullet half-size in pixels
GRAZE_R, 12, graze half-size in pixels (used only with GRAZE_EN)

Ports:
clk  in  1  system clock
hard_reset  in  1  asynchronous, active-high reset
game_en  in  1  scanning allowed while high (driven by the game FSM)
game_reset  in  1  synchronous soft clear (pulse from the game FSM)
frame_tick  in  1  one-cycle pulse at the start of each frame
player_x  in  COORD_W  player centre x
player_y  in  COORD_W  player centre y
bullet_rd  out  1  read strobe to the bullet table
bullet_addr  out  log2(N_BULLETS)  bullet slot address
bullet_data  in  1+2*COORD_W  {valid, x, y}; valid the cycle after bullet_rd
collision  out  1  one-cycle pulse: at least one hit this frame
hit_index  out  log2(N_BULLETS)  lowest-index hit slot of the last reporting frame
busy  out  1  high while a scan is in progress
overrun  out  1  sticky: a frame_tick arrived while busy
graze  out  1  one-cycle graze pulse (GRAZE_EN only; otherwise tied 0)

Behaviour:
- Reset is hard_reset, asynchronous, active-high; the clock is clk.
- Reset values: every output is 0; the state is IDLE.
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE:
  - When frame_tick and game_en are both high, latch player_x and player_y, clear the per-frame hit flags, and go to SCAN.
  - A frame_tick with game_en low is ignored.
- SCAN:
  - Assert bullet_rd with bullet_addr = 0, 1, ..., N_BULLETS-1, one address per cycle.
  - After issuing address N_BULLETS-1, go to DRAIN.
- Compare stage:
  - In the cycle after each read, evaluate the returned bullet_data against the latched player position.
  - Hit condition: valid && |bx-px| <= HIT_R+BULLET_R && |by-py| <= HIT_R+BULLET_R.
  - Compute each difference at COORD_W+1 bits, unsigned, with no wrap.
  - The first hit in a frame records its slot as the pending index; later hits in the same frame do not change it.
- DRAIN: evaluates the final slot's data, then goes to REPORT.
- REPORT:
  - collision = 1 for exactly this one cycle if any hit occurred.
  - If a hit occurred, update hit_index to the pending index; otherwise hit_index holds its previous value.
  - Return to IDLE.
- busy is high in SCAN, DRAIN and REPORT.
- Latency: frame_tick in cycle t → address 0 in t+1 → last address in t+N_BULLETS → collision in t+N_BULLETS+2. The next frame_tick is accepted from t+N_BULLETS+3.
- A frame_tick while busy is dropped and sets overrun. overrun stays set until game_reset or hard_reset.
- game_en falling in SCAN or DRAIN: abort to IDLE in the next cycle with no collision pulse. The read in flight is discarded.
- game_reset, in any state, takes priority over frame_tick. It returns the block to IDLE and clears hit_index, overrun, the per-frame hit flags, and all pulses.
- Slot wrap: bullet_addr never wraps inside a scan. Each frame scans each slot exactly once.

Optional Feature:
- Macro: GRAZE_EN.
- Defined:
  - Each valid bullet is also tested against the graze box: |d| <= GRAZE_R+BULLET_R on both axes.
  - A slot counts as a graze only if it passes the graze test and is not a hit.
  - graze pulses in REPORT, coincident with collision, if any graze occurred.
- Undefined: no graze logic is built and graze is tied to 0.

Decomposition:
- Shared package stg_pkg holds:
  - the state encoding for IDLE/SCAN/DRAIN/REPORT;
  - COORD_W;
  - the bullet record field offsets (valid bit, x slice, y slice);
  - the default half-sizes.
- One sub-module, box_overlap:
  - Combinational abs-diff plus compare for one axis pair and one radius.
  - Instantiated once for hit, and once more under GRAZE_EN.

Test Plan:
1. Player (100,100); only slot 5 valid at (105,98); frame_tick at t → collision pulse at t+66 only, hit_index=5, busy low from t+67.
2. Slots 7 and 3 valid at (100,100) → a single collision pulse; hit_index=3 (lowest index wins).
3. Player (0,0); bullet at (1023,0) valid; all others invalid → no collision (no wrap in the difference). Bullet at (7,7) → hit; (8,0) → no hit (boundary at 7).
4. frame_tick at t and again at t+10 → the second tick is ignored and overrun=1; game_reset → overrun=0, hit_index=0.
5. game_en dropped at t+20 with a hit present at slot 2 → no collision pulse; IDLE at t+21; the next frame scans normally.
6. GRAZE_EN: bullet at (110,100), player (100,100) → graze=1, collision=0; bullet at (104,100) → collision=1, graze=0.
